// File: rtl/inst_prefetch_if.sv
// Prefetcher bus bundle: redirect, instruction-memory request/response and core-side valid/ready.
// master = prefetcher side, slave = environment (ctrl, memory, fetch stage).
interface inst_prefetch_if;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;

  modport master (
    input  jump_en_i, jump_addr_i, mem_ready_i, mem_rvalid_i, mem_rdata_i, inst_ready_i,
    output mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o
  );

  modport slave (
    output jump_en_i, jump_addr_i, mem_ready_i, mem_rvalid_i, mem_rdata_i, inst_ready_i,
    input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o
  );
endinterface

// File: rtl/inst_prefetch.sv
// Sequential instruction prefetch FIFO; response-to-valid 1 cycle (0 with IPF_BYPASS_EN); jump flushes.
// Backpressure: requests stop once queued + in-flight kept words would exceed DEPTH.
module inst_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst_n,
  inst_prefetch_if.master bus
);
  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam int unsigned   CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d, fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]   addr_mem_q [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic [CW:0] pending;
  logic        accept, keep, push, pop, fifo_vld;

  // Dropped words are already counted in out_cnt, so they do not hold back new requests.
  assign pending        = {1'b0, fifo_cnt_q} + {1'b0, out_cnt_q} - {1'b0, drop_cnt_q};
  assign bus.mem_req_o  = rst_n && !bus.jump_en_i && (pending < DEPTH_W) && (out_cnt_q < DEPTH_C);
  assign bus.mem_addr_o = fetch_pc_q;
  assign accept         = bus.mem_req_o && bus.mem_ready_i;
  assign keep           = bus.mem_rvalid_i && (drop_cnt_q == '0) && !bus.jump_en_i;
  assign fifo_vld       = rst_n && (fifo_cnt_q != '0);
  assign pop            = fifo_vld && bus.inst_ready_i && !bus.jump_en_i;

`ifdef IPF_BYPASS_EN
  logic bypass;
  assign bypass           = rst_n && keep && !fifo_vld;
  assign bus.inst_valid_o = fifo_vld || bypass;
  assign bus.inst_o       = fifo_vld ? inst_mem_q[rd_ptr_q] : (bypass ? bus.mem_rdata_i : '0);
  assign bus.inst_addr_o  = fifo_vld ? addr_mem_q[rd_ptr_q] : (bypass ? resp_pc_q : '0);
  assign push             = keep && !(bypass && bus.inst_ready_i);
`else
  assign bus.inst_valid_o = fifo_vld;
  assign bus.inst_o       = fifo_vld ? inst_mem_q[rd_ptr_q] : '0;
  assign bus.inst_addr_o  = fifo_vld ? addr_mem_q[rd_ptr_q] : '0;
  assign push             = keep;
`endif

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    fifo_cnt_d = fifo_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (bus.jump_en_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = bus.jump_addr_i;
      resp_pc_d  = bus.jump_addr_i;
      out_cnt_d  = out_cnt_q - CW'(bus.mem_rvalid_i);
      drop_cnt_d = out_cnt_q - CW'(bus.mem_rvalid_i);
      fifo_cnt_d = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      out_cnt_d = out_cnt_q + CW'(accept) - CW'(bus.mem_rvalid_i);
      if (bus.mem_rvalid_i && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      if (keep) resp_pc_d = resp_pc_q + 32'd4;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= resp_pc_q;
      inst_mem_q[wr_ptr_q] <= bus.mem_rdata_i;
    end
  end
endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch: in-order memory model with fixed latency plus accept/pop logs.
module tb_inst_prefetch;
  logic clk = 1'b0;
  logic rst_n;
  inst_prefetch_if bus();

  inst_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef IPF_BYPASS_EN
  localparam int unsigned RSP_LAT = 1;
`else
  localparam int unsigned RSP_LAT = 2;
`endif

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] addr;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [31:0] acc_addr_q[$], acc_cyc_q[$], pop_addr_q[$], pop_inst_q[$], pop_cyc_q[$];
  int unsigned cyc, lat;
  int          checks, failures;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: drive memory response, log the handshakes, advance the memory model.
  task automatic cycle();
    logic        rv, acc;
    logic [31:0] a;
    if (!rst_n) rsp_q.delete();
    rv = rst_n && (rsp_q.size() != 0) && (rsp_q[0].due <= cyc);
    bus.mem_rvalid_i = rv;
    bus.mem_rdata_i  = rv ? inst_of(rsp_q[0].addr) : 32'h0;
    #1;
    acc = bus.mem_req_o && bus.mem_ready_i;
    a   = bus.mem_addr_o;
    if (acc) begin
      acc_addr_q.push_back(a);
      acc_cyc_q.push_back(cyc);
    end
    if (bus.inst_valid_o && bus.inst_ready_i && !bus.jump_en_i) begin
      pop_addr_q.push_back(bus.inst_addr_o);
      pop_inst_q.push_back(bus.inst_o);
      pop_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    if (rv) void'(rsp_q.pop_front());
    if (acc) rsp_q.push_back('{due: cyc + lat, addr: a});
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_logs();
    acc_addr_q.delete(); acc_cyc_q.delete();
    pop_addr_q.delete(); pop_inst_q.delete(); pop_cyc_q.delete();
  endtask

  task automatic restart(input int unsigned l, input logic rdy);
    rst_n = 1'b0;
    bus.jump_en_i = 1'b0; bus.jump_addr_i = 32'h0;
    bus.inst_ready_i = rdy; bus.mem_ready_i = 1'b1;
    lat = l;
    run(2);
    clear_logs();
    cyc = 0;
    rst_n = 1'b1;
  endtask

  task automatic first_acc(input int unsigned after, output logic [31:0] a, output logic [31:0] c, output int n);
    a = 32'hDEAD_BEEF; c = 32'hFFFF_FFFF; n = 0;
    foreach (acc_addr_q[i]) if (acc_cyc_q[i] > after) begin
      if (n == 0) begin a = acc_addr_q[i]; c = acc_cyc_q[i]; end
      n++;
    end
  endtask

  task automatic first_pop(input int unsigned after, output logic [31:0] a, output logic [31:0] c, output int bad);
    int n = 0;
    a = 32'hDEAD_BEEF; c = 32'hFFFF_FFFF; bad = 0;
    foreach (pop_addr_q[i]) if (pop_cyc_q[i] > after) begin
      if (n == 0) begin a = pop_addr_q[i]; c = pop_cyc_q[i]; end
      if (pop_addr_q[i] < 32'h100) bad++;
      n++;
    end
  endtask

  logic [31:0] fa, fc;
  int          n;

  initial begin
    checks = 0; failures = 0; cyc = 0; lat = 1;
    rst_n = 1'b0;
    bus.jump_en_i = 1'b0; bus.jump_addr_i = 32'h0; bus.inst_ready_i = 1'b1;
    bus.mem_ready_i = 1'b1; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'h0;

    // Reset values, then streaming at 1-cycle memory latency.
    run(2);
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_inst_valid", bus.inst_valid_o, 0);
    clear_logs(); cyc = 0; rst_n = 1'b1; #1;
    chk("rel_mem_req", bus.mem_req_o, 1);
    chk("rel_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rel_inst_valid", bus.inst_valid_o, 0);
    chk("rel_inst", bus.inst_o, 32'h0);
    chk("rel_inst_addr", bus.inst_addr_o, 32'h0);
    run(8);
    chk("t1_acc_n", 32'(acc_addr_q.size()), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_acc_addr", acc_addr_q[i], 32'(4 * i));
      chk("t1_acc_cyc", acc_cyc_q[i], 32'(i));
    end
    chk("t1_pop_n", 32'(pop_addr_q.size()), 32'(8 - RSP_LAT));
    chk("t1_inst0", pop_inst_q[0], 32'h0000_0013);
    for (int i = 0; i < 6; i++) begin
      chk("t1_pop_addr", pop_addr_q[i], 32'(4 * i));
      chk("t1_pop_inst", pop_inst_q[i], inst_of(32'(4 * i)));
      chk("t1_pop_cyc", pop_cyc_q[i], 32'(RSP_LAT + i));
    end

    // Consumer stalled: exactly DEPTH accepts, then drain in order.
    restart(1, 1'b0);
    run(10);
    chk("t2_acc_n", 32'(acc_addr_q.size()), 4);
    for (int i = 0; i < 4; i++) chk("t2_acc_addr", acc_addr_q[i], 32'(4 * i));
    chk("t2_req_stall", bus.mem_req_o, 0);
    chk("t2_head_valid", bus.inst_valid_o, 1);
    chk("t2_head_addr", bus.inst_addr_o, 32'h0);
    bus.inst_ready_i = 1'b1;
    run(8);
    for (int i = 0; i < 4; i++) chk("t2_pop_addr", pop_addr_q[i], 32'(4 * i));
    chk("t2_resume", acc_addr_q[4], 32'h10);

    // Jump with three requests in flight at latency 3.
    restart(3, 1'b1);
    run(3);
    bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'h100;
    cycle();
    bus.jump_en_i = 1'b0; #1;
    chk("t3_valid_n1", bus.inst_valid_o, 0);
    chk("t3_req_n1", bus.mem_req_o, 1);
    chk("t3_addr_n1", bus.mem_addr_o, 32'h100);
    run(12);
    first_acc(3, fa, fc, n);
    chk("t3_acc_addr", fa, 32'h100);
    chk("t3_acc_cyc", fc, 4);
    first_pop(3, fa, fc, n);
    chk("t3_pop_addr", fa, 32'h100);
    chk("t3_stale_pops", 32'(n), 0);

    // Jump in the same cycle as a pop and a response.
    restart(1, 1'b1);
    run(4);
    chk("t4_pre_valid", bus.inst_valid_o, 1);
    bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'h100;
    cycle();
    bus.jump_en_i = 1'b0; #1;
    chk("t4_valid_n1", bus.inst_valid_o, 0);
    chk("t4_addr_n1", bus.mem_addr_o, 32'h100);
    run(6);
    first_acc(4, fa, fc, n);
    chk("t4_acc_addr", fa, 32'h100);
    chk("t4_acc_cyc", fc, 5);
    first_pop(4, fa, fc, n);
    chk("t4_pop_addr", fa, 32'h100);
    chk("t4_pop_cyc", fc, 32'(5 + RSP_LAT));
    chk("t4_stale_pops", 32'(n), 0);

    // Back-to-back jumps; stalled consumer shows in-flight accounting settles.
    restart(3, 1'b1);
    run(3);
    bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'h200;
    cycle();
    bus.jump_addr_i = 32'h300;
    cycle();
    bus.jump_en_i = 1'b0; bus.inst_ready_i = 1'b0;
    run(15);
    first_acc(2, fa, fc, n);
    chk("t5_acc_addr", fa, 32'h300);
    chk("t5_acc_cyc", fc, 5);
    chk("t5_acc_n", 32'(n), 4);
    chk("t5_req_stall", bus.mem_req_o, 0);
    chk("t5_head_addr", bus.inst_addr_o, 32'h300);
    chk("t5_head_inst", bus.inst_o, inst_of(32'h300));
    bus.inst_ready_i = 1'b1;
    run(4);
    for (int i = 0; i < 4; i++) chk("t5_pop_addr", pop_addr_q[i], 32'h300 + 32'(4 * i));

    // Reset pulse mid-stream with two queued and two in flight.
    restart(2, 1'b0);
    run(4);
    chk("t6_pre_valid", bus.inst_valid_o, 1);
    rst_n = 1'b0; #1;
    chk("t6_rst_req", bus.mem_req_o, 0);
    cycle();
    clear_logs();
    rst_n = 1'b1; #1;
    chk("t6_valid", bus.inst_valid_o, 0);
    chk("t6_inst", bus.inst_o, 32'h0);
    chk("t6_inst_addr", bus.inst_addr_o, 32'h0);
    chk("t6_req", bus.mem_req_o, 1);
    chk("t6_addr", bus.mem_addr_o, 32'h0);
    bus.inst_ready_i = 1'b1;
    run(6);
    chk("t6_acc_addr", acc_addr_q[0], 32'h0);
    chk("t6_pop_addr", pop_addr_q[0], 32'h0);
    chk("t6_pop_inst", pop_inst_q[0], 32'h0000_0013);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
